// File: rtl/mux_pkt_nto1.sv
// Registered N:1 packet multiplexer; the select is locked from a packet's first beat through its last beat.
// Optional sticky out-of-range select flag: define MUX_PKT_SEL_ERR_EN to add the sel_err port.
module mux_pkt_nto1 #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic [SELW-1:0]    lock_sel
`ifdef MUX_PKT_SEL_ERR_EN
    ,output logic              sel_err
`endif
);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

    localparam logic [SELW:0] NCH = (SELW+1)'(N);

    state_e            state_q, state_d;
    logic [SELW-1:0]   lock_sel_q, lock_sel_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;

    logic [SELW-1:0]   cur;
    logic              cur_ok;
    logic              can_load;
    logic              xfer;
    logic [WIDTH-1:0]  cur_data;
    logic              cur_valid;
    logic              cur_last;

    assign cur      = (state_q == IDLE) ? sel : lock_sel_q;
    assign cur_ok   = ({1'b0, cur} < NCH);
    assign can_load = !out_valid_q || out_ready;

    // Loop-based pick keeps out-of-range selects from ever indexing past in_data.
    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cur_ok && cur == SELW'(i)) begin
                cur_data  = in_data[i*WIDTH +: WIDTH];
                cur_valid = in_valid[i];
                cur_last  = in_last[i];
            end
        end
    end

    assign xfer = cur_valid && can_load;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        case (state_q)
            IDLE: if (xfer) begin
                lock_sel_d = sel;
                if (!cur_last) state_d = LOCK;
            end
            LOCK: if (xfer && cur_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++)
            in_ready[i] = cur_ok && (cur == SELW'(i)) && can_load;
        busy     = (state_q == LOCK);
        lock_sel = lock_sel_q;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = cur_data;
            out_last_d  = cur_last;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

`ifdef MUX_PKT_SEL_ERR_EN
    logic sel_err_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                           sel_err_q <= 1'b0;
        else if (state_q == IDLE && !cur_ok) sel_err_q <= 1'b1;
    end
    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_pkt_nto1.sv
// Directed bench for mux_pkt_nto1: a 4-channel and a 3-channel instance sharing clock and reset.
module tb_mux_pkt_nto1;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;

    logic [1:0]   sel4;
    logic [127:0] data4;
    logic [3:0]   vld4, last4, rdy4;
    logic [31:0]  odata4;
    logic         ovld4, olast4, ordy4, busy4;
    logic [1:0]   lsel4;

    logic [1:0]   sel3;
    logic [95:0]  data3;
    logic [2:0]   vld3, last3, rdy3;
    logic [31:0]  odata3;
    logic         ovld3, olast3, ordy3, busy3;
    logic [1:0]   lsel3;
`ifdef MUX_PKT_SEL_ERR_EN
    logic         serr4, serr3;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    mux_pkt_nto1 #(.WIDTH(32), .N(4), .SELW(2)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .sel(sel4), .in_data(data4), .in_valid(vld4),
        .in_last(last4), .in_ready(rdy4), .out_data(odata4), .out_valid(ovld4),
        .out_last(olast4), .out_ready(ordy4), .busy(busy4), .lock_sel(lsel4)
`ifdef MUX_PKT_SEL_ERR_EN
        , .sel_err(serr4)
`endif
    );

    mux_pkt_nto1 #(.WIDTH(32), .N(3), .SELW(2)) u_dut3 (
        .Clk(Clk), .Reset(Reset), .sel(sel3), .in_data(data3), .in_valid(vld3),
        .in_last(last3), .in_ready(rdy3), .out_data(odata3), .out_valid(ovld3),
        .out_last(olast3), .out_ready(ordy3), .busy(busy3), .lock_sel(lsel3)
`ifdef MUX_PKT_SEL_ERR_EN
        , .sel_err(serr3)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic beat4(input int ch, input logic [31:0] d, input logic l);
        vld4  = '0;
        last4 = '0;
        data4[ch*32 +: 32] = d;
        vld4[ch]  = 1'b1;
        last4[ch] = l;
    endtask

    initial begin
        sel4 = 2'd0; data4 = '0; vld4 = '0; last4 = '0; ordy4 = 1'b1;
        sel3 = 2'd0; data3 = '0; vld3 = '0; last3 = '0; ordy3 = 1'b1;

        // reset state
        #1 Reset = 1'b1;
        #1;
        chk("rst_ovalid", 64'(ovld4), 64'h0);
        chk("rst_odata",  64'(odata4), 64'h0);
        chk("rst_olast",  64'(olast4), 64'h0);
        chk("rst_busy",   64'(busy4), 64'h0);
        chk("rst_lsel",   64'(lsel4), 64'h0);
        #6 Reset = 1'b0;
        tick;

        // single-beat packet on ch2
        sel4 = 2'd2;
        beat4(2, 32'hDEADBEEF, 1'b1);
        #1 chk("t1_ready", 64'(rdy4), 64'h4);
        tick;
        chk("t1_ovalid", 64'(ovld4), 64'h1);
        chk("t1_odata",  64'(odata4), 64'hDEADBEEF);
        chk("t1_olast",  64'(olast4), 64'h1);
        chk("t1_busy",   64'(busy4), 64'h0);
        chk("t1_lsel",   64'(lsel4), 64'h2);
        vld4 = '0;
        tick;
        chk("t1_drain",  64'(ovld4), 64'h0);
        chk("t1_hold",   64'(odata4), 64'hDEADBEEF);

        // 3-beat packet on ch1; sel moves to 3 mid-packet, ch3 stays valid
        sel4 = 2'd1;
        beat4(1, 32'hA1, 1'b0);
        data4[3*32 +: 32] = 32'h333; vld4[3] = 1'b1; last4[3] = 1'b1;
        #1 chk("t2_ready0", 64'(rdy4), 64'h2);
        tick;
        chk("t2_b1", 64'(odata4), 64'hA1);
        chk("t2_busy1", 64'(busy4), 64'h1);
        chk("t2_lsel", 64'(lsel4), 64'h1);
        sel4 = 2'd3;
        data4[1*32 +: 32] = 32'hA2;
        #1 chk("t2_ready1", 64'(rdy4), 64'h2);
        tick;
        chk("t2_b2", 64'(odata4), 64'hA2);
        chk("t2_busy2", 64'(busy4), 64'h1);
        data4[1*32 +: 32] = 32'hA3; last4[1] = 1'b1;
        #1 chk("t2_ready2", 64'(rdy4), 64'h2);
        tick;
        chk("t2_b3", 64'(odata4), 64'hA3);
        chk("t2_last", 64'(olast4), 64'h1);
        chk("t2_busy3", 64'(busy4), 64'h0);
        chk("t2_lsel_hold", 64'(lsel4), 64'h1);
        vld4 = '0;
        tick;

        // backpressure for 5 cycles, then no-bubble streaming
        sel4 = 2'd0;
        beat4(0, 32'hB0, 1'b0);
        ordy4 = 1'b0;
        tick;
        chk("t3_load", 64'(odata4), 64'hB0);
        data4[0 +: 32] = 32'hB1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_stable", 64'(odata4), 64'hB0);
            chk("t3_vld", 64'(ovld4), 64'h1);
            chk("t3_noready", 64'(rdy4), 64'h0);
            tick;
        end
        ordy4 = 1'b1;
        #1 chk("t3_ready", 64'(rdy4), 64'h1);
        tick;
        chk("t3_b1", 64'(odata4), 64'hB1);
        chk("t3_busy", 64'(busy4), 64'h1);
        data4[0 +: 32] = 32'hB2; last4[0] = 1'b1;
        tick;
        chk("t3_b2", 64'(odata4), 64'hB2);
        chk("t3_b2vld", 64'(ovld4), 64'h1);
        chk("t3_b2last", 64'(olast4), 64'h1);
        chk("t3_idle", 64'(busy4), 64'h0);
        vld4 = '0;
        tick;

        // out-of-range select on the 3-channel instance
`ifdef MUX_PKT_SEL_ERR_EN
        chk("t4_serr0", 64'(serr3), 64'h0);
`endif
        sel3 = 2'd3; vld3 = 3'b111; last3 = 3'b111;
        data3 = {32'hC2, 32'hC1, 32'hC0};
        #1 chk("t4_ready", 64'(rdy3), 64'h0);
        tick;
        chk("t4_ovalid", 64'(ovld3), 64'h0);
        chk("t4_busy", 64'(busy3), 64'h0);
`ifdef MUX_PKT_SEL_ERR_EN
        chk("t4_serr1", 64'(serr3), 64'h1);
        chk("t4_serr4", 64'(serr4), 64'h0);
`endif
        sel3 = 2'd0; vld3 = '0;
        tick;
`ifdef MUX_PKT_SEL_ERR_EN
        chk("t4_sticky", 64'(serr3), 64'h1);
`endif
        sel3 = 2'd2; vld3 = 3'b100;
        #1 chk("t4_ready_top", 64'(rdy3), 64'h4);
        tick;
        chk("t4_top_data", 64'(odata3), 64'hC2);
        chk("t4_top_lsel", 64'(lsel3), 64'h2);
        vld3 = '0;
        tick;

        // async reset mid-packet
        sel4 = 2'd1;
        beat4(1, 32'hD0, 1'b0);
        tick;
        chk("t5_pre_busy", 64'(busy4), 64'h1);
        chk("t5_pre_vld", 64'(ovld4), 64'h1);
        #2 Reset = 1'b1;
        #1;
        chk("t5_ovalid", 64'(ovld4), 64'h0);
        chk("t5_busy", 64'(busy4), 64'h0);
        chk("t5_olast", 64'(olast4), 64'h0);
        chk("t5_odata", 64'(odata4), 64'h0);
        chk("t5_lsel", 64'(lsel4), 64'h0);
`ifdef MUX_PKT_SEL_ERR_EN
        chk("t5_serr", 64'(serr3), 64'h0);
`endif
        Reset = 1'b0;
        sel4 = 2'd3;
        beat4(3, 32'hE3, 1'b1);
        #1 chk("t5_ready", 64'(rdy4), 64'h8);
        tick;
        chk("t5_data", 64'(odata4), 64'hE3);
        chk("t5_last", 64'(olast4), 64'h1);
        chk("t5_lsel3", 64'(lsel4), 64'h3);
        chk("t5_idle", 64'(busy4), 64'h0);
        vld4 = '0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
